axi_sram_slave: RTL and testbench

- AXI3 responder (slave) memory model; the other end of the CPU-side AXI master port (arbitrated I/D cache + uncached traffic).
- Serves INCR bursts from a word-addressed on-chip RAM. Used as the bench/FPGA memory behind the core, and as the reference responder for the cache refill/writeback paths.
- Handles one transaction at a time, with no outstanding overlap.

---
 rtl/axi_defs_pkg.sv | 17 +
 rtl/sram_bytewe.sv | 22 ++
 rtl/axi_sram_slave.sv | 186 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_defs_pkg.sv
// Shared AXI3 definitions for the CPU-side memory responder and its arbiter.
package axi_defs_pkg;

  localparam int unsigned ID_W  = 4;
  localparam int unsigned LEN_W = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BURST,
    S_WR_DATA,
    S_WR_RESP
  } state_t;

endpackage

// File: rtl/sram_bytewe.sv
// Single-port word RAM with per-byte write enables and an asynchronous read port.
module sram_bytewe #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [3:0]           we,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 INCR-burst responder backed by a word-addressed on-chip RAM.
// One transaction at a time; reads win over writes when both arrive together.
module axi_sram_slave
  import axi_defs_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ID_W-1:0]  arid,
  input  logic [31:0]      araddr,
  input  logic [LEN_W-1:0] arlen,
  input  logic             arvalid,
  output logic             arready,
  output logic [ID_W-1:0]  rid,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  output logic             rlast,
  output logic             rvalid,
  input  logic             rready,
  input  logic [ID_W-1:0]  awid,
  input  logic [31:0]      awaddr,
  input  logic [LEN_W-1:0] awlen,
  input  logic             awvalid,
  output logic             awready,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             wlast,
  input  logic             wvalid,
  output logic             wready,
  output logic [ID_W-1:0]  bid,
  output logic [1:0]       bresp,
  output logic             bvalid,
  input  logic             bready
);

  localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  state_t               state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     beat_q;
  logic [1:0]           wait_q;
  logic [ID_W-1:0]      rid_q;
  logic [ID_W-1:0]      bid_q;
  logic [31:0]          rdata_q;
  logic                 rvalid_q;
  logic                 rlast_q;
  logic                 bvalid_q;

  logic [LEN_W-1:0]     beat_nxt;
  logic [ADDR_BITS-1:0] cur_idx;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [3:0]           ram_we;
  logic [31:0]          ram_rdata;
  logic                 unused_addr_bits;

  assign beat_nxt = beat_q + LEN_W'(1);
  assign cur_idx  = addr_q + ADDR_BITS'(beat_q);

  assign arready = (state == S_IDLE) && !rst;
  assign awready = (state == S_IDLE) && !rst && !arvalid;
  assign wready  = (state == S_WR_DATA) && !rst;

  // The RAM port is steered one word ahead of the registered rdata so the next
  // beat is already on the read bus when the current one is accepted.
  always_comb begin
    ram_addr = addr_q;
    case (state)
      S_IDLE:     ram_addr = araddr[ADDR_BITS+1:2];
      S_RD_WAIT:  ram_addr = addr_q;
      S_RD_BURST: ram_addr = cur_idx + ADDR_BITS'(1);
      S_WR_DATA:  ram_addr = cur_idx;
      default:    ram_addr = addr_q;
    endcase
  end

  assign ram_we = (wready && wvalid) ? wstrb : '0;

  sram_bytewe #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
      rid_q    <= '0;
      bid_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arvalid) begin
            addr_q <= araddr[ADDR_BITS+1:2];
            len_q  <= arlen;
            rid_q  <= arid;
            beat_q <= '0;
            wait_q <= '0;
            if (RD_LAT == 1) begin
              state    <= S_RD_BURST;
              rvalid_q <= 1'b1;
              rlast_q  <= (arlen == '0);
              rdata_q  <= ram_rdata;
            end else begin
              state <= S_RD_WAIT;
            end
          end else if (awvalid) begin
            addr_q <= awaddr[ADDR_BITS+1:2];
            len_q  <= awlen;
            bid_q  <= awid;
            beat_q <= '0;
            state  <= S_WR_DATA;
          end
        end
        S_RD_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state    <= S_RD_BURST;
            rvalid_q <= 1'b1;
            rlast_q  <= (len_q == '0);
            rdata_q  <= ram_rdata;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        S_RD_BURST: begin
          if (rready) begin
            if (rlast_q) begin
              state    <= S_IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              beat_q  <= beat_nxt;
              rdata_q <= ram_rdata;
              rlast_q <= (beat_nxt == len_q);
            end
          end
        end
        S_WR_DATA: begin
          if (wvalid) begin
            if (beat_q == len_q) begin
              state    <= S_WR_RESP;
              bvalid_q <= 1'b1;
            end else begin
              beat_q <= beat_nxt;
            end
          end
        end
        S_WR_RESP: begin
          if (bready) begin
            state    <= S_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rid    = rid_q;
  assign rdata  = rdata_q;
  assign rresp  = RESP_OKAY;
  assign rlast  = rlast_q;
  assign rvalid = rvalid_q;
  assign bid    = bid_q;
  assign bresp  = RESP_OKAY;
  assign bvalid = bvalid_q;

  // Byte-offset bits, aliased upper address bits and wlast carry no meaning here.
  assign unused_addr_bits = ^{araddr[31:ADDR_BITS+2], araddr[1:0],
                              awaddr[31:ADDR_BITS+2], awaddr[1:0], wlast};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave against a flat word-array memory model.
module tb_axi_sram_slave;

  localparam int unsigned ADDR_BITS = 12;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned DEPTH     = 2**ADDR_BITS;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_sram_slave #(
    .ADDR_BITS (ADDR_BITS),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } rexp_t;

  rexp_t       r_q[$];
  logic [3:0]  b_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          rr_mode = 0;
  bit          br_hold = 1'b0;

  function automatic int unsigned widx(input logic [31:0] byte_addr, input int unsigned beat);
    return ((byte_addr >> 2) + beat) % DEPTH;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rr_mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    bready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bready = br_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops expectations on every R/B handshake and checks R stability under stall.
  initial begin
    rexp_t       e;
    logic [3:0]  eb;
    logic        pstall;
    logic [31:0] pdata;
    logic [3:0]  pid;
    logic        plast;
    pstall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          chk("r_hold_valid", rvalid, 1'b1);
          chk("r_hold_data", rdata, pdata);
          chk("r_hold_id", rid, pid);
          chk("r_hold_last", rlast, plast);
        end
        if (rvalid && rready) begin
          if (r_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL r_unexpected: got beat %h with no read outstanding", rdata);
          end else begin
            e = r_q.pop_front();
            chk("r_data", rdata, e.data);
            chk("r_id", rid, e.id);
            chk("r_last", rlast, e.last);
            chk("r_resp", rresp, 2'b00);
          end
        end
        if (bvalid && bready) begin
          if (b_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_unexpected: got bid %h with no write outstanding", bid);
          end else begin
            eb = b_q.pop_front();
            chk("b_id", bid, eb);
            chk("b_resp", bresp, 2'b00);
          end
        end
        pstall = rvalid && !rready;
        pdata  = rdata;
        pid    = rid;
        plast  = rlast;
      end
    end
  end

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input bit chk_coll);
    int k;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (arready) break;
      if (++k > 200) begin timeout("ar_accept"); arvalid = 1'b0; return; end
    end
    if (chk_coll) chk("collide_awready", awready, 1'b0);
    for (int b = 0; b <= int'(len); b++)
      r_q.push_back('{data: model_mem[widx(addr, b)], id: id, last: (b == int'(len))});
    @(posedge clk); #1;
    arvalid = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      if (rvalid || k > 20) break;
    end
    chk("r_latency", k, RD_LAT);
  endtask

  task automatic wait_r_done();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (r_q.size() == 0) break;
      if (++k > 500) begin timeout("r_done"); r_q.delete(); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic aw_issue(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    int k;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (awready) break;
      if (++k > 200) begin timeout("aw_accept"); awvalid = 1'b0; return; end
    end
    b_q.push_back(id);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] addr, input int nbeats);
    int k;
    int unsigned ix;
    for (int b = 0; b < nbeats; b++) begin
      wvalid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
      k = 0;
      forever begin
        @(negedge clk);
        if (wready) break;
        if (++k > 200) begin timeout("w_accept"); wvalid = 1'b0; return; end
      end
      ix = widx(addr, b);
      for (int i = 0; i < 4; i++)
        if (ws[b][i]) model_mem[ix][8*i +: 8] = wd[b][8*i +: 8];
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_b_done();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (b_q.size() == 0) break;
      if (++k > 500) begin timeout("b_done"); b_q.delete(); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    aw_issue(id, addr, len);
    w_send(addr, int'(len) + 1);
    wait_b_done();
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    ar_issue(id, addr, len, 1'b0);
    wait_r_done();
  endtask

  task automatic fill_wd(input bit rand_strb);
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom();
      ws[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_arready"}, arready, 1'b0);
    chk({tag, "_awready"}, awready, 1'b0);
    chk({tag, "_wready"}, wready, 1'b0);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_rlast"}, rlast, 1'b0);
    chk({tag, "_bvalid"}, bvalid, 1'b0);
    chk({tag, "_rid"}, rid, 4'h0);
    chk({tag, "_bid"}, bid, 4'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    write_burst(4'd1, 32'h40, 4'd0);
    read_burst(4'd3, 32'h40, 4'd0);

    // 8-beat read with alternating rready
    for (int i = 0; i < 8; i++) begin wd[i] = i; ws[i] = 4'hF; end
    write_burst(4'd2, 32'h0, 4'd7);
    rr_mode = 1;
    read_burst(4'd4, 32'h0, 4'd7);
    rr_mode = 0;

    // Masked write then read-back
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    write_burst(4'd5, 32'h10, 4'd0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    write_burst(4'd5, 32'h10, 4'd0);
    read_burst(4'd6, 32'h10, 4'd0);

    // W presented before any AW is held off
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("w_early_wready", wready, 1'b0);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;

    // Simultaneous AR and AW: read first, then the write with B stalled
    fill_wd(1'b0);
    awid = 4'd7; awaddr = 32'h80; awlen = 4'd1; awvalid = 1'b1;
    ar_issue(4'd8, 32'h0, 4'd3, 1'b1);
    wait_r_done();
    br_hold = 1'b1;
    aw_issue(4'd7, 32'h80, 4'd1);
    w_send(32'h80, 2);
    repeat (4) begin
      @(negedge clk);
      chk("b_held", bvalid, 1'b1);
      @(posedge clk); #1;
    end
    br_hold = 1'b0;
    wait_b_done();
    read_burst(4'd9, 32'h80, 4'd1);

    // Address wrap, plus aliasing through ignored upper address bits
    fill_wd(1'b0);
    write_burst(4'd9, 32'h3FF8, 4'd3);
    read_burst(4'd10, 32'h3FF8, 4'd3);
    read_burst(4'd11, 32'h8000_3FF8, 4'd3);

    // Reset in the middle of a 4-beat write
    fill_wd(1'b0);
    write_burst(4'd12, 32'h400, 4'd3);
    fill_wd(1'b0);
    aw_issue(4'd12, 32'h400, 4'd3);
    w_send(32'h400, 2);
    rst = 1'b1;
    b_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_b", bvalid, 1'b0);
      chk("midrst_no_r", rvalid, 1'b0);
      @(posedge clk); #1;
    end
    read_burst(4'd13, 32'h400, 4'd3);

    // Randomized traffic over an initialized 64-word region
    for (int blk = 0; blk < 4; blk++) begin
      fill_wd(1'b0);
      write_burst(4'($urandom_range(0, 15)), 32'(blk * 64), 4'd15);
    end
    rr_mode = 2;
    for (int t = 0; t < 30; t++) begin
      a = (32'($urandom_range(0, 47)) << 2) | ($urandom() & 32'hFFFF_C000);
      if ($urandom_range(0, 1) == 1) begin
        fill_wd(1'b1);
        write_burst(4'($urandom_range(0, 15)), a, 4'($urandom_range(0, 15)));
      end else begin
        read_burst(4'($urandom_range(0, 15)), a, 4'($urandom_range(0, 15)));
      end
    end
    rr_mode = 0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
